// File: rtl/packet_send_engine_pkg.sv
// Shared definitions for the packet send engine and the switch-side header parser.
package packet_send_engine_pkg;

  // Parameter defaults
  localparam int unsigned PORT_NUB_TOTAL_DEF  = 16;
  localparam int unsigned DATA_WIDTH_DEF      = 32;
  localparam int unsigned DATA_LENGTH_MAX_DEF = 512;
  localparam int unsigned PRIORITY_DEF        = 8;

  // Derived widths
  localparam int unsigned WIDTH_SEL      = $clog2(PORT_NUB_TOTAL_DEF);
  localparam int unsigned WIDTH_LENGTH   = $clog2(DATA_LENGTH_MAX_DEF);
  localparam int unsigned WIDTH_PRIORITY = $clog2(PRIORITY_DEF);
  // Low header bits holding the request itself (dest, priority, length)
  localparam int unsigned WIDTH_HAND     = WIDTH_SEL + WIDTH_PRIORITY + WIDTH_LENGTH;
  localparam int unsigned WIDTH_SEQ      = 16;

  // Header field offsets
  localparam int unsigned DEST_LSB = 0;
  localparam int unsigned PRI_LSB  = 4;
  localparam int unsigned LEN_LSB  = 7;
  localparam int unsigned SEQ_LSB  = 16;

  typedef enum logic [1:0] {
    StIdle,
    StHead,
    StBody,
    StDone
  } state_e;

  // Build a header word from its fields
  function automatic logic [DATA_WIDTH_DEF-1:0] pack_header(
    input logic [WIDTH_SEL-1:0]      dest,
    input logic [WIDTH_PRIORITY-1:0] pri,
    input logic [WIDTH_LENGTH-1:0]   len,
    input logic [WIDTH_SEQ-1:0]      seq
  );
    logic [DATA_WIDTH_DEF-1:0] hdr;
    hdr = '0;
    hdr[DEST_LSB +: WIDTH_SEL]      = dest;
    hdr[PRI_LSB  +: WIDTH_PRIORITY] = pri;
    hdr[LEN_LSB  +: WIDTH_LENGTH]   = len;
    hdr[SEQ_LSB  +: WIDTH_SEQ]      = seq;
    return hdr;
  endfunction

endpackage

// File: rtl/packet_send_engine.sv
// Per-ingress-port packet generator: header word then payload words, no backpressure.
module packet_send_engine
  import packet_send_engine_pkg::*;
#(
  parameter int unsigned PORT_NUB_TOTAL  = PORT_NUB_TOTAL_DEF,
  parameter int unsigned DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int unsigned DATA_LENGTH_MAX = DATA_LENGTH_MAX_DEF,
  parameter int unsigned PRIORITY        = PRIORITY_DEF
) (
  input  logic                                clk,
  input  logic                                rst_n,   // synchronous, active-high
  input  logic                                start,
  input  logic [$clog2(PORT_NUB_TOTAL)-1:0]   dest,
  // "priority" is a reserved word, hence the short name
  input  logic [$clog2(PRIORITY)-1:0]         prio,
  input  logic [$clog2(DATA_LENGTH_MAX)-1:0]  length,
  output logic                                ready,
  output logic                                done,
  output logic                                wr_sop,
  output logic                                wr_eop,
  output logic                                wr_vld,
  output logic [DATA_WIDTH-1:0]               wr_data
);

  localparam int unsigned WSel = $clog2(PORT_NUB_TOTAL);
  localparam int unsigned WPri = $clog2(PRIORITY);
  localparam int unsigned WLen = $clog2(DATA_LENGTH_MAX);

  state_e                state_q, state_d;
  logic [WIDTH_SEQ-1:0]  seq_q, seq_d;
  logic [WLen-1:0]       k_q, k_d;
  logic [WSel-1:0]       dest_q, dest_d;
  logic [WPri-1:0]       pri_q, pri_d;
  logic [WLen-1:0]       len_q, len_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;
  logic                  sop_q, sop_d;
  logic                  eop_q, eop_d;
  logic                  vld_q, vld_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  // Next state plus next registered outputs; outputs describe the cycle being entered
  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    k_d     = k_q;
    dest_d  = dest_q;
    pri_d   = pri_q;
    len_d   = len_q;
    ready_d = 1'b0;
    done_d  = 1'b0;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    vld_d   = 1'b0;
    data_d  = '0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          dest_d  = dest;
          pri_d   = prio;
          len_d   = length;
          state_d = StHead;
          sop_d   = 1'b1;
          vld_d   = 1'b1;
          eop_d   = (length == '0);
          data_d  = DATA_WIDTH'(pack_header(dest, prio, length, seq_q));
        end else begin
          state_d = StIdle;
          ready_d = 1'b1;
        end
      end
      StHead: begin
        if (len_q == '0) begin
          state_d = StDone;
          done_d  = 1'b1;
          ready_d = 1'b1;
          seq_d   = seq_q + WIDTH_SEQ'(1);
        end else begin
          state_d = StBody;
          k_d     = '0;
          vld_d   = 1'b1;
          eop_d   = (len_q == WLen'(1));
          data_d  = DATA_WIDTH'({seq_q, 16'h0000});
        end
      end
      StBody: begin
        if (k_q + WLen'(1) == len_q) begin
          // Word just shown was the last one
          state_d = StDone;
          done_d  = 1'b1;
          ready_d = 1'b1;
          seq_d   = seq_q + WIDTH_SEQ'(1);
        end else begin
          // k_q + 2 <= len_q here, so no wrap
          k_d    = k_q + WLen'(1);
          vld_d  = 1'b1;
          eop_d  = (k_q + WLen'(2) == len_q);
          data_d = DATA_WIDTH'({seq_q, 16'(k_q + WLen'(1))});
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, captured fields and registered outputs
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= StIdle;
      seq_q   <= '0;
      k_q     <= '0;
      dest_q  <= '0;
      pri_q   <= '0;
      len_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      vld_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      k_q     <= k_d;
      dest_q  <= dest_d;
      pri_q   <= pri_d;
      len_q   <= len_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
    end
  end

  assign ready   = ready_q;
  assign done    = done_q;
  assign wr_sop  = sop_q;
  assign wr_eop  = eop_q;
  assign wr_vld  = vld_q;
  assign wr_data = data_q;

endmodule

// File: tb/tb_packet_send_engine.sv
// Self-checking bench for packet_send_engine: vector table, hand sequences, random sweep.
module tb_packet_send_engine;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  dest;
  logic [2:0]  prio;
  logic [8:0]  length;
  logic        ready;
  logic        done;
  logic        wr_sop;
  logic        wr_eop;
  logic        wr_vld;
  logic [31:0] wr_data;

  int checks = 0;
  int errors = 0;
  int seq_m  = 0;

  packet_send_engine dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .dest    (dest),
    .prio    (prio),
    .length  (length),
    .ready   (ready),
    .done    (done),
    .wr_sop  (wr_sop),
    .wr_eop  (wr_eop),
    .wr_vld  (wr_vld),
    .wr_data (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          d;
    int          p;
    int          l;
    int          gap;
    logic [31:0] hdr;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference header: fields placed by arithmetic from the documented layout
  function automatic logic [31:0] hdr_model(input int seq, input int d, input int p, input int l);
    return 32'((seq % 65536) * 65536 + l * 128 + p * 16 + d);
  endfunction

  function automatic logic [31:0] word_model(input int seq, input int k);
    return 32'((seq % 65536) * 65536 + k);
  endfunction

  task automatic scramble();
    dest   = 4'($urandom);
    prio   = 3'($urandom);
    length = 9'($urandom);
  endtask

  // Entered and left at a negedge. Sends one packet and checks every cycle of it.
  task automatic send_pkt(input int d, input int p, input int l, input int gap,
                          input int poke_at, input bit use_tbl, input logic [31:0] tbl_hdr);
    int nv, ns, ne;
    logic [31:0] exp_hdr;
    nv = 0; ns = 0; ne = 0;
    repeat (gap) @(negedge clk);
    chk("ready_before_start", ready, 1);
    start  = 1'b1;
    dest   = 4'(d);
    prio   = 3'(p);
    length = 9'(l);
    @(negedge clk);
    start = 1'b0;
    scramble();
    exp_hdr = use_tbl ? tbl_hdr : hdr_model(seq_m, d, p, l);
    chk("header_data", wr_data, exp_hdr);
    chk("header_sop", wr_sop, 1);
    chk("header_eop", wr_eop, (l == 0) ? 1 : 0);
    chk("ready_busy", ready, 0);
    nv += int'(wr_vld); ns += int'(wr_sop); ne += int'(wr_eop);
    for (int k = 0; k < l; k++) begin
      if (k == poke_at) begin
        start = 1'b1;
        dest  = 4'(d ^ 1);
      end
      @(negedge clk);
      start = 1'b0;
      scramble();
      chk("body_data", wr_data, word_model(seq_m, k));
      chk("body_eop", wr_eop, (k == l - 1) ? 1 : 0);
      nv += int'(wr_vld); ns += int'(wr_sop); ne += int'(wr_eop);
    end
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("done_ready", ready, 1);
    chk("done_vld", wr_vld, 0);
    chk("done_data", wr_data, 0);
    chk("vld_count", nv, l + 1);
    chk("sop_count", ns, 1);
    chk("eop_count", ne, 1);
    seq_m++;
  endtask

  vec_t vecs[5];

  initial begin
    rst_n  = 1'b1;
    start  = 1'b0;
    dest   = '0;
    prio   = '0;
    length = '0;

    // seq numbers in hdr follow table order from reset
    vecs[0] = '{d: 5,  p: 2, l: 15,  gap: 1, hdr: 32'h000007A5};
    vecs[1] = '{d: 3,  p: 7, l: 0,   gap: 0, hdr: 32'h00010073};
    vecs[2] = '{d: 15, p: 0, l: 1,   gap: 2, hdr: 32'h0002008F};
    vecs[3] = '{d: 0,  p: 5, l: 511, gap: 0, hdr: 32'h0003FFD0};
    vecs[4] = '{d: 9,  p: 1, l: 2,   gap: 0, hdr: 32'h00040119};

    // Reset held 10 cycles
    repeat (10) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_vld", wr_vld, 0);
    chk("rst_done", done, 0);
    chk("rst_sop", wr_sop, 0);
    chk("rst_eop", wr_eop, 0);
    chk("rst_data", wr_data, 0);
    rst_n = 1'b0;
    @(negedge clk);

    // Table vectors; zero gaps exercise a start in the DONE cycle
    foreach (vecs[i]) begin
      send_pkt(vecs[i].d, vecs[i].p, vecs[i].l, vecs[i].gap, -1, 1'b1, vecs[i].hdr);
    end

    // start during BODY is ignored: no second packet follows
    send_pkt(7, 4, 8, 1, 3, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_second_pkt_vld", wr_vld, 0);
      chk("no_second_pkt_ready", ready, 1);
    end

    // Random sweep
    for (int r = 0; r < 20; r++) begin
      int rl;
      rl = int'($urandom & 240) + 15;
      send_pkt(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)), rl,
               int'($urandom_range(0, 2)), -1, 1'b0, 32'h0);
    end

    // Reset mid-BODY
    start  = 1'b1;
    dest   = 4'd6;
    prio   = 3'd1;
    length = 9'd20;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_vld", wr_vld, 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_vld", wr_vld, 0);
    chk("midrst_sop", wr_sop, 0);
    chk("midrst_eop", wr_eop, 0);
    chk("midrst_data", wr_data, 0);
    chk("midrst_ready", ready, 1);
    chk("midrst_done", done, 0);
    rst_n = 1'b0;
    seq_m = 0;
    @(negedge clk);
    // seq cleared: next header carries seq 0
    send_pkt(2, 3, 4, 0, -1, 1'b1, 32'h00000232);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
